// File: rtl/uart_port_arbiter.sv
// Purpose: shares one UartComm byte FIFO pair among PORTS requesters using header+payload framing.
// Latency: TX ack N+2 cycles after req is seen (N payload bytes); RX rx_valid one cycle after last byte pop.
// Backpressure: sendable low freezes TX in place; receivable low stalls RX and runs the timeout in R_BODY.
module uart_port_arbiter #(
   parameter int PORTS   = 2,
   parameter int TIMEOUT = 100000
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [PORTS-1:0]    req,
   input  logic [64*PORTS-1:0] req_data,
   input  logic [3*PORTS-1:0]  req_len,
   output logic [PORTS-1:0]    ack,
   output logic [PORTS-1:0]    rx_valid,
   output logic [63:0]         rx_data,
   output logic [2:0]          rx_len,
   output logic [7:0]          err_cnt,
   output logic                send_flag,
   output logic [7:0]          send_data,
   input  logic                sendable,
   output logic                recv_flag,
   input  logic [7:0]          recv_data,
   input  logic                receivable
);
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {T_IDLE, T_HEAD, T_BODY} tx_state_t;
   typedef enum logic {R_HEAD, R_BODY} rx_state_t;

   tx_state_t t_state, t_next;
   rx_state_t r_state, r_next;

   logic [1:0]       last_grant;
   logic             gnt_vld;
   logic [1:0]       gnt_id;
   logic [63:0]      gnt_data;
   logic [2:0]       gnt_len;
   logic [63:0]      tx_data;
   logic [2:0]       tx_len;
   logic [2:0]       tx_idx;
   logic [1:0]       tx_id;
   logic             tx_last;
   logic [PORTS-1:0] tx_ack_dec;

   logic [1:0]       rx_id;
   logic [2:0]       rx_lenr;
   logic [2:0]       rx_idx;
   logic [63:0]      rx_asm;
   logic [63:0]      rx_asm_nxt;
   logic [TW-1:0]    idle_cnt;
   logic             rx_last;
   logic             rx_port_ok;
   logic             rx_timeout;
   logic             rx_err;
   logic [PORTS-1:0] rx_dec;

   assign tx_last    = (tx_idx == tx_len);
   assign rx_last    = (rx_idx == rx_lenr);
   assign rx_port_ok = (int'(rx_id) < PORTS);
   assign rx_timeout = (idle_cnt == TW'(TIMEOUT - 1));
   assign rx_err     = (r_state == R_BODY) &&
                       ((receivable && rx_last && !rx_port_ok) || (!receivable && rx_timeout));

   // Round-robin pick: nearest requester after last_grant wins; last_grant itself is lowest priority.
   always_comb begin
      gnt_vld  = 1'b0;
      gnt_id   = '0;
      gnt_data = '0;
      gnt_len  = '0;
      for (int k = PORTS; k >= 1; k--) begin
         for (int p = 0; p < PORTS; p++) begin
            if (req[p] && (p == (int'(last_grant) + k) % PORTS)) begin
               gnt_vld  = 1'b1;
               gnt_id   = 2'(p);
               gnt_data = req_data[64*p +: 64];
               gnt_len  = req_len[3*p +: 3];
            end
         end
      end
   end

   // One-hot port decodes for the ack and rx_valid pulses, plus the RX byte insertion.
   always_comb begin
      tx_ack_dec = '0;
      rx_dec     = '0;
      for (int p = 0; p < PORTS; p++) begin
         tx_ack_dec[p] = (tx_id == 2'(p));
         rx_dec[p]     = (rx_id == 2'(p));
      end
      rx_asm_nxt = rx_asm;
      rx_asm_nxt[{rx_idx, 3'b000} +: 8] = recv_data;
   end

   // TX next state and push strobe; header while in T_HEAD, indexed payload byte in T_BODY.
   always_comb begin
      t_next    = t_state;
      send_flag = 1'b0;
      send_data = 8'h00;
      case (t_state)
         T_IDLE: if (gnt_vld) t_next = T_HEAD;
         T_HEAD: begin
            send_flag = sendable;
            send_data = {tx_id, 3'b000, tx_len};
            if (sendable) t_next = T_BODY;
         end
         T_BODY: begin
            send_flag = sendable;
            send_data = tx_data[{tx_idx, 3'b000} +: 8];
            if (sendable && tx_last) t_next = T_IDLE;
         end
         default: t_next = T_IDLE;
      endcase
   end

   // RX next state and pop strobe; every available byte is consumed in either state.
   always_comb begin
      r_next    = r_state;
      recv_flag = 1'b0;
      case (r_state)
         R_HEAD: begin
            recv_flag = receivable;
            if (receivable) r_next = R_BODY;
         end
         R_BODY: begin
            recv_flag = receivable;
            if (receivable) begin
               if (rx_last) r_next = R_HEAD;
            end else if (rx_timeout) begin
               r_next = R_HEAD;
            end
         end
         default: r_next = R_HEAD;
      endcase
   end

   // State registers for the two independent FSMs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         t_state <= T_IDLE;
         r_state <= R_HEAD;
      end else begin
         t_state <= t_next;
         r_state <= r_next;
      end
   end

   // TX datapath: latch the granted packet, step the byte index, pulse ack after the last byte.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         last_grant <= 2'(PORTS - 1);
         tx_data    <= '0;
         tx_len     <= '0;
         tx_id      <= '0;
         tx_idx     <= '0;
         ack        <= '0;
      end else begin
         ack <= '0;
         if (t_state == T_IDLE && gnt_vld) begin
            last_grant <= gnt_id;
            tx_id      <= gnt_id;
            tx_data    <= gnt_data;
            tx_len     <= gnt_len;
            tx_idx     <= '0;
         end
         if (t_state == T_BODY && sendable) begin
            if (tx_last) begin
               ack    <= tx_ack_dec;
               tx_idx <= '0;
            end else begin
               tx_idx <= tx_idx + 3'd1;
            end
         end
      end
   end

   // RX datapath: parse header, assemble payload, deliver or drop, run the inter-byte timeout.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rx_id    <= '0;
         rx_lenr  <= '0;
         rx_idx   <= '0;
         rx_asm   <= '0;
         idle_cnt <= '0;
         rx_valid <= '0;
         rx_data  <= '0;
         rx_len   <= '0;
         err_cnt  <= '0;
      end else begin
         rx_valid <= '0;
         case (r_state)
            R_HEAD: begin
               idle_cnt <= '0;
               if (receivable) begin
                  rx_id   <= recv_data[7:6];
                  rx_lenr <= recv_data[2:0];
                  rx_asm  <= '0;
                  rx_idx  <= '0;
               end
            end
            R_BODY: begin
               if (receivable) begin
                  idle_cnt <= '0;
                  rx_asm   <= rx_asm_nxt;
                  if (rx_last) begin
                     rx_idx <= '0;
                     if (rx_port_ok) begin
                        rx_valid <= rx_dec;
                        rx_data  <= rx_asm_nxt;
                        rx_len   <= rx_lenr;
                     end
                  end else begin
                     rx_idx <= rx_idx + 3'd1;
                  end
               end else if (rx_timeout) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + TW'(1);
               end
            end
            default: idle_cnt <= '0;
         endcase
         if (rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Purpose: self-checking bench for uart_port_arbiter with a queue-based framing/round-robin model.
// Latency: checks ack and rx_valid timing cycle-exactly against byte-level expectations.
// Backpressure: drives sendable/receivable constant, random or toggling per phase.
module tb_uart_port_arbiter;
   localparam int PORTS   = 2;
   localparam int TIMEOUT = 40;

   typedef struct { logic [1:0] port; logic [2:0] len; logic [63:0] data; } pkt_t;
   typedef struct { logic [7:0] b; bit last; int port; } txb_t;
   typedef struct { logic [7:0] b; int tag; int port; } rxb_t;   // tag 0 mid, 1 deliver, 2 drop
   typedef struct { int port; logic [63:0] data; logic [2:0] len; } dlv_t;

   logic                CLK = 1'b0;
   logic                RST_N;
   logic [PORTS-1:0]    req;
   logic [64*PORTS-1:0] req_data;
   logic [3*PORTS-1:0]  req_len;
   logic [PORTS-1:0]    ack;
   logic [PORTS-1:0]    rx_valid;
   logic [63:0]         rx_data;
   logic [2:0]          rx_len;
   logic [7:0]          err_cnt;
   logic                send_flag;
   logic [7:0]          send_data;
   logic                sendable;
   logic                recv_flag;
   logic [7:0]          recv_data;
   logic                receivable;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ack_cyc = -1;
   int model_last;
   int model_err;
   int snd_mode;
   int rcv_mode;
   bit err_pending;
   logic [PORTS-1:0] ack_exp;
   logic [PORTS-1:0] rxv_exp;

   pkt_t txq [PORTS][$];
   txb_t exp_tx[$];
   rxb_t rxq[$];
   dlv_t exp_rx[$];

   uart_port_arbiter #(.PORTS(PORTS), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .req_data(req_data), .req_len(req_len),
      .ack(ack), .rx_valid(rx_valid), .rx_data(rx_data), .rx_len(rx_len), .err_cnt(err_cnt),
      .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
      .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh_req();
      for (int p = 0; p < PORTS; p++) begin
         req[p] = (txq[p].size() > 0);
         if (txq[p].size() > 0) begin
            req_data[64*p +: 64] = txq[p][0].data;
            req_len[3*p +: 3]    = txq[p][0].len;
         end
      end
   endtask

   task automatic add_tx(input int port, input logic [2:0] len, input logic [63:0] data);
      pkt_t pk;
      pk.port = 2'(port);
      pk.len  = len;
      pk.data = data;
      txq[port].push_back(pk);
   endtask

   // Expected byte stream: serve non-empty queues round-robin starting after model_last.
   task automatic plan_tx();
      int   cnt [PORTS];
      int   p;
      bit   any;
      pkt_t pk;
      txb_t e;
      for (int i = 0; i < PORTS; i++) cnt[i] = 0;
      do begin
         any = 0;
         for (int k = 1; k <= PORTS; k++) begin
            p = (model_last + k) % PORTS;
            if (!any && cnt[p] < txq[p].size()) begin
               any = 1;
               pk = txq[p][cnt[p]];
               cnt[p]++;
               model_last = p;
               e.b = {pk.port, 3'b000, pk.len};
               e.last = 0;
               e.port = p;
               exp_tx.push_back(e);
               for (int i = 0; i <= int'(pk.len); i++) begin
                  e.b = pk.data[8*i +: 8];
                  e.last = (i == int'(pk.len));
                  exp_tx.push_back(e);
               end
            end
         end
      end while (any);
      refresh_req();
   endtask

   task automatic push_rx(input logic [7:0] b, input int tag, input int port);
      rxb_t r;
      r.b = b;
      r.tag = tag;
      r.port = port;
      rxq.push_back(r);
   endtask

   task automatic add_rx(input int port, input logic [2:0] len, input logic [63:0] data);
      dlv_t d;
      logic [63:0] m;
      m = '0;
      push_rx({2'(port), 3'b000, len}, 0, port);
      for (int i = 0; i <= int'(len); i++) begin
         m[8*i +: 8] = data[8*i +: 8];
         push_rx(data[8*i +: 8], (i == int'(len)) ? ((port < PORTS) ? 1 : 2) : 0, port);
      end
      if (port < PORTS) begin
         d.port = port;
         d.data = m;
         d.len  = len;
         exp_rx.push_back(d);
      end
   endtask

   task automatic drive_rx();
      receivable = (rxq.size() > 0) && (rcv_mode == 0 || $urandom_range(0, 1) == 1);
      recv_data  = (rxq.size() > 0) ? rxq[0].b : 8'($urandom);
   endtask

   // One clock: check combinational outputs at negedge, registered outputs just after posedge.
   task automatic tick();
      bit   did_pop;
      txb_t e;
      dlv_t d;
      @(negedge CLK);
      chk("recv_flag", recv_flag, receivable);
      if (!sendable) chk("send_gate", send_flag, 0);
      did_pop = recv_flag && receivable;
      if (send_flag) begin
         if (exp_tx.size() == 0) begin
            chk("tx_extra", 1, 0);
         end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", send_data, e.b);
            if (e.last) ack_exp[e.port] = 1'b1;
         end
      end
      if (did_pop && rxq.size() > 0) begin
         if (rxq[0].tag == 1) rxv_exp[rxq[0].port] = 1'b1;
         else if (rxq[0].tag == 2) err_pending = 1;
      end
      @(posedge CLK);
      #1;
      cyc++;
      chk("ack", ack, ack_exp);
      if (ack != '0) ack_cyc = cyc;
      chk("rx_valid", rx_valid, rxv_exp);
      if (rxv_exp != '0 && exp_rx.size() > 0) begin
         d = exp_rx.pop_front();
         chk("rx_data", rx_data, d.data);
         chk("rx_len", rx_len, d.len);
      end
      if (err_pending && model_err < 255) model_err++;
      err_pending = 0;
      ack_exp = '0;
      rxv_exp = '0;
      if (did_pop && rxq.size() > 0) void'(rxq.pop_front());
      for (int p = 0; p < PORTS; p++)
         if (ack[p] && txq[p].size() > 0) void'(txq[p].pop_front());
      if (ack != '0) refresh_req();
      case (snd_mode)
         0:       sendable = 1'b1;
         1:       sendable = ($urandom_range(0, 3) != 0);
         default: sendable = !sendable;
      endcase
      drive_rx();
   endtask

   function automatic int pending();
      int n;
      n = exp_tx.size() + rxq.size() + exp_rx.size();
      for (int p = 0; p < PORTS; p++) n += txq[p].size();
      return n;
   endfunction

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (pending() > 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
      chk("drain", pending(), 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ack", ack, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_len", rx_len, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_send_flag", send_flag, 0);
      chk("rst_send_data", send_data, 0);
      chk("rst_recv_flag", recv_flag, 0);
   endtask

   initial begin
      int t0;
      RST_N = 1'b0;
      req = '0;
      req_data = '0;
      req_len = '0;
      sendable = 1'b0;
      recv_data = '0;
      receivable = 1'b0;
      model_last = PORTS - 1;
      model_err = 0;
      snd_mode = 0;
      rcv_mode = 0;
      err_pending = 0;
      ack_exp = '0;
      rxv_exp = '0;
      repeat (3) @(posedge CLK);
      #1;
      chk_reset_outputs();
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Single port-0 packet, len 3; data changed after grant must not leak into the stream.
      sendable = 1'b1;
      add_tx(0, 3'd2, 64'h1122334455CCBBAA);
      plan_tx();
      t0 = cyc;
      tick();
      req_data[63:0] = 64'hDEADBEEF0BADF00D;
      drain(50);
      chk("ack_latency", 64'(ack_cyc - t0), 5);

      // Both ports requesting continuously, len 1 each: grants alternate.
      for (int i = 0; i < 3; i++) begin
         add_tx(0, 3'd0, {$urandom, $urandom});
         add_tx(1, 3'd0, {$urandom, $urandom});
      end
      plan_tx();
      drain(100);

      // RX delivery to port 1, then hold of rx_data/rx_len between packets.
      add_rx(1, 3'd1, 64'h2211);
      drive_rx();
      drain(50);
      chk("rx_hold_data", rx_data, 64'h2211);
      chk("rx_hold_len", rx_len, 1);
      chk("err_none", err_cnt, model_err);

      // Bad port id is dropped and counted; following packet still arrives.
      add_rx(3, 3'd0, 64'h55);
      add_rx(0, 3'd1, 64'h4433);
      drive_rx();
      drain(50);
      chk("err_bad_port", err_cnt, 1);

      // Stalled packet times out after exactly TIMEOUT idle cycles.
      push_rx(8'h03, 0, 0);
      push_rx(8'h01, 0, 0);
      drive_rx();
      for (int n = 0; n < 10 && rxq.size() > 0; n++) tick();
      chk("stall_fed", rxq.size(), 0);
      repeat (TIMEOUT - 1) tick();
      chk("err_before_timeout", err_cnt, model_err);
      tick();
      model_err++;
      chk("err_timeout", err_cnt, model_err);
      add_rx(0, 3'd0, 64'h7E);
      drive_rx();
      drain(50);
      chk("rx_after_timeout", rx_data, 64'h7E);

      // Random traffic on both directions with random backpressure.
      snd_mode = 1;
      rcv_mode = 1;
      for (int p = 0; p < PORTS; p++)
         for (int i = 0; i < 4; i++)
            add_tx(p, 3'($urandom_range(0, 7)), {$urandom, $urandom});
      plan_tx();
      for (int i = 0; i < 12; i++)
         add_rx($urandom_range(0, 3), 3'($urandom_range(0, 7)), {$urandom, $urandom});
      drive_rx();
      drain(3000);
      chk("err_random", err_cnt, model_err);

      // Len-8 packet with sendable toggling every cycle.
      snd_mode = 2;
      rcv_mode = 0;
      add_tx(1, 3'd7, 64'h8877665544332211);
      plan_tx();
      drain(100);

      // Second len-8 packet aborted by reset mid-way; port 0 must win first afterwards.
      add_tx(0, 3'd7, {$urandom, $urandom});
      plan_tx();
      repeat (7) tick();
      chk("err_pre_reset", err_cnt, model_err);
      RST_N = 1'b0;
      receivable = 1'b0;
      #1;
      chk_reset_outputs();
      exp_tx.delete();
      rxq.delete();
      exp_rx.delete();
      for (int p = 0; p < PORTS; p++) txq[p].delete();
      model_last = PORTS - 1;
      model_err = 0;
      ack_exp = '0;
      rxv_exp = '0;
      refresh_req();
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
      snd_mode = 0;
      add_tx(0, 3'd0, 64'hA5);
      add_tx(1, 3'd0, 64'h5A);
      plan_tx();
      drain(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
